// File: rtl/prod_acc_pkg.sv
// Shared types and constants for the 128-bit product accumulator.
// Saturating adds are selected by defining PROD_ACC_SAT_EN.
package prod_acc_pkg;

  localparam int PROD_W    = 128;
  localparam int ACC_W_DEF = 136;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/prod_acc_add.sv
// Accumulator adder: ACC_W-bit sum of a and zero-extended b, with carry.
// PROD_ACC_SAT_EN clamps the sum to all-ones on carry out; otherwise it wraps.
module prod_acc_add
  import prod_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] raw;

  assign raw   = {1'b0, a} + {1'b0, ACC_W'(b)};
  assign carry = raw[ACC_W];

`ifdef PROD_ACC_SAT_EN
  assign sum = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
  assign sum = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/prod_acc_128.sv
// Multi-term accumulator for 128-bit products with valid/ready in and out.
// Build option PROD_ACC_SAT_EN selects saturating instead of wrapping sums.
module prod_acc_128
  import prod_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf
);

  if (ACC_W < PROD_W) begin : g_chk
    $error("prod_acc_128: ACC_W must be at least 128");
  end

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_c;
  logic             xfer;

  prod_acc_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .a     (acc_q),
    .b     (in_prod),
    .sum   (add_sum),
    .carry (add_c)
  );

  assign in_ready  = (state_q != HOLD);
  assign xfer      = in_valid & in_ready;
  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_cnt   = cnt_q;
  assign out_ovf   = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          acc_d   = ACC_W'(in_prod);
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (xfer) begin
          acc_d   = add_sum;
          cnt_d   = cnt_q + CNT_W'(1);
          // count wrap is a overflow just like a carry out
          ovf_d   = ovf_q | add_c | (&cnt_q);
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_prod_acc_128.sv
// Directed bench for prod_acc_128: default instance plus a narrow
// ACC_W=128/CNT_W=2 instance for overflow and count wrap.
module tb_prod_acc_128;
  import prod_acc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              a_in_valid = 1'b0;
  logic [PROD_W-1:0] a_in_prod  = '0;
  logic              a_in_last  = 1'b0;
  logic              a_in_ready;
  logic              a_out_valid;
  logic              a_out_ready = 1'b0;
  logic [135:0]      a_out_sum;
  logic [7:0]        a_out_cnt;
  logic              a_out_ovf;

  logic              b_in_valid = 1'b0;
  logic [PROD_W-1:0] b_in_prod  = '0;
  logic              b_in_last  = 1'b0;
  logic              b_in_ready;
  logic              b_out_valid;
  logic              b_out_ready = 1'b0;
  logic [127:0]      b_out_sum;
  logic [1:0]        b_out_cnt;
  logic              b_out_ovf;

  prod_acc_128 u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_prod   (a_in_prod),
    .in_last   (a_in_last),
    .in_ready  (a_in_ready),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_sum   (a_out_sum),
    .out_cnt   (a_out_cnt),
    .out_ovf   (a_out_ovf)
  );

  prod_acc_128 #(
    .ACC_W (128),
    .CNT_W (2)
  ) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_prod   (b_in_prod),
    .in_last   (b_in_last),
    .in_ready  (b_in_ready),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_sum   (b_out_sum),
    .out_cnt   (b_out_cnt),
    .out_ovf   (b_out_ovf)
  );

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] F0   = {4'hF, 124'h0};

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [127:0] p, input logic last);
    a_in_valid = 1'b1;
    a_in_prod  = p;
    a_in_last  = last;
    tick();
    a_in_valid = 1'b0;
    a_in_prod  = '0;
    a_in_last  = 1'b0;
  endtask

  task automatic send_b(input logic [127:0] p, input logic last);
    b_in_valid = 1'b1;
    b_in_prod  = p;
    b_in_last  = last;
    tick();
    b_in_valid = 1'b0;
    b_in_prod  = '0;
    b_in_last  = 1'b0;
  endtask

  task automatic pop_a();
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic pop_b();
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
  endtask

  task automatic check_a(input string tag, input logic v,
                         input logic [135:0] s, input logic [7:0] c,
                         input logic o);
    check({tag, "_valid"}, 256'(a_out_valid), 256'(v));
    check({tag, "_sum"},   256'(a_out_sum),   256'(s));
    check({tag, "_cnt"},   256'(a_out_cnt),   256'(c));
    check({tag, "_ovf"},   256'(a_out_ovf),   256'(o));
  endtask

  logic [127:0] exp_ovf_sum;
  logic [127:0] exp_sticky_sum;

  initial begin
`ifdef PROD_ACC_SAT_EN
    exp_ovf_sum    = ONES;
    exp_sticky_sum = ONES;
`else
    exp_ovf_sum    = 128'd1;
    exp_sticky_sum = 128'd6;
`endif

    #3;
    check_a("rst", 1'b0, '0, '0, 1'b0);
    check("rst_ready", 256'(a_in_ready), 256'(1));
    check("rst_b_ready", 256'(b_in_ready), 256'(1));
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    send_a(128'd5, 1'b1);
    check_a("single", 1'b1, 136'd5, 8'd1, 1'b0);
    check("single_rdy", 256'(a_in_ready), 256'(0));
    pop_a();
    check_a("pop1", 1'b0, '0, '0, 1'b0);
    check("pop1_rdy", 256'(a_in_ready), 256'(1));

    send_a(128'd3, 1'b0);
    check("t3_mid_valid", 256'(a_out_valid), 256'(0));
    send_a(128'd4, 1'b0);
    send_a(F0, 1'b1);
    check_a("three", 1'b1, {8'h0, F0 | 128'd7}, 8'd3, 1'b0);
    pop_a();

    send_a(128'd1, 1'b1);
    a_in_valid = 1'b1;
    a_in_prod  = 128'd99;
    a_in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_rdy", 256'(a_in_ready), 256'(0));
      check_a("bp", 1'b1, 136'd1, 8'd1, 1'b0);
      tick();
    end
    a_in_valid = 1'b0;
    pop_a();
    check_a("bp_pop", 1'b0, '0, '0, 1'b0);
    check("bp_pop_rdy", 256'(a_in_ready), 256'(1));

    send_b(ONES, 1'b0);
    send_b(128'd2, 1'b1);
    check("ovf_valid", 256'(b_out_valid), 256'(1));
    check("ovf_sum", 256'(b_out_sum), 256'(exp_ovf_sum));
    check("ovf_cnt", 256'(b_out_cnt), 256'(2));
    check("ovf_flag", 256'(b_out_ovf), 256'(1));
    pop_b();
    check("ovf_clr", 256'(b_out_ovf), 256'(0));

    send_b(ONES, 1'b0);
    send_b(128'd2, 1'b0);
    send_b(128'd5, 1'b1);
    check("sticky_sum", 256'(b_out_sum), 256'(exp_sticky_sum));
    check("sticky_cnt", 256'(b_out_cnt), 256'(3));
    check("sticky_ovf", 256'(b_out_ovf), 256'(1));
    pop_b();

    for (int i = 0; i < 3; i++) send_b(128'd1, 1'b0);
    check("cnt3_ovf", 256'(b_out_ovf), 256'(0));
    send_b(128'd1, 1'b1);
    check("wrap_sum", 256'(b_out_sum), 256'(4));
    check("wrap_cnt", 256'(b_out_cnt), 256'(0));
    check("wrap_ovf", 256'(b_out_ovf), 256'(1));
    pop_b();

    send_a(128'd1, 1'b0);
    send_a(128'd2, 1'b0);
    rst = 1'b1;
    #2;
    check_a("rst_mid", 1'b0, '0, '0, 1'b0);
    check("rst_mid_rdy", 256'(a_in_ready), 256'(1));
    @(negedge clk);
    rst = 1'b0;
    tick();
    send_a(128'd7, 1'b1);
    check_a("after_rst", 1'b1, 136'd7, 8'd1, 1'b0);
    rst = 1'b1;
    #2;
    check_a("rst_hold", 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    send_a(128'd2, 1'b0);
    a_in_prod = 128'd100;
    a_in_last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_a("gap", 1'b0, 136'd2, 8'd1, 1'b0);
      check("gap_rdy", 256'(a_in_ready), 256'(1));
    end
    send_a(128'd9, 1'b1);
    check_a("gaps", 1'b1, 136'd11, 8'd2, 1'b0);
    pop_a();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
